cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
- Control block for the CNN accelerator memory subsystem.
- Tracks host loading of the input image and the four weight regions, and generates per-region write strobes and offsets for the memory banks.
- Once every region is loaded, runs the four layers in order with a start/done handshake.
- Exposes a status byte and a control register to the host over the same chipselect/read/write bus.

Parameters:
- NUM_LAYERS, 4, number of layers to sequence (layer i = region i+1).
- CNT_W, 18, width of the region write-offset counters.
- INPUT_SIZE, 10000, bytes in region 0 (input image).
- L1_SIZE, 400, bytes in region 1.
- L2_SIZE, 12800, bytes in region 2.
- L3_SIZE, 230400, bytes in region 3.
- L4_SIZE, 10600, bytes in region 4.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- chipselect  in  1  host bus select
- write  in  1  host write strobe
- read  in  1  host read strobe
- address  in  3  0-4 region select, 5 status, 6 control
- writedata  in  8  host data; only bits[1:0] are used, at address 6
- mem_we  out  5  one-hot write enable to the region memories; combinational from the bus
- mem_offset  out  CNT_W  write offset for the selected region's memory
- layer_start  out  NUM_LAYERS  one-cycle start pulse, one-hot
- layer_done  in  NUM_LAYERS  done pulses from the layer engines
- readdata  out  8  status byte
- irq  out  1  high while result_valid

Behaviour:
- Reset: all counters 0; loaded flags 0; state LOAD; layer_idx 0; layer_start 0; readdata 0; error flags 0; irq 0.
- Region write (chipselect && write, address 0-4, state LOAD or FINISHED):
  - if cnt[r] < SIZE[r]: mem_we[r]=1 and mem_offset=cnt[r] in the same cycle; cnt[r] increments at the clock edge.
  - loaded[r] sets on the clock edge where cnt[r] reaches SIZE[r].
  - if cnt[r] == SIZE[r]: write dropped, mem_we=0, ovf flag sets.
- Region write in RUN or WAIT: dropped, mem_we=0, busy_err flag sets.
- Control write (address 6), only honoured in LOAD or FINISHED; ignored in RUN/WAIT and sets busy_err:
  - bit1 = full clear: all counters, loaded flags, result_valid and error flags cleared.
  - bit0 = new image: cnt[0], loaded[0] and result_valid cleared; weights stay loaded.
  - bit1 has priority when both are set.
- FSM:
  - LOAD: when all five loaded flags are 1, go to RUN with layer_idx=0.
  - FINISHED: when loaded[0] becomes 1 again (new image), go to RUN with layer_idx=0.
  - RUN (1 cycle): assert layer_start[layer_idx] for exactly one cycle; go to WAIT.
  - WAIT: on layer_done[layer_idx]=1, either increment layer_idx and go to RUN, or, if layer_idx==NUM_LAYERS-1, set result_valid and go to FINISHED.
  - done bits for other layers are ignored in WAIT. All done inputs are ignored outside WAIT; a done coincident with layer_start is not seen.
  - Gap from done to the next start = 1 cycle; first start arrives 1 cycle after the last load write.
- Status read (address 5, chipselect && read): readdata registered, 1-cycle latency.
  - Bit fields: [0] all_loaded, [1] busy (RUN/WAIT), [2] result_valid, [3] ovf, [4] busy_err, [7:5] layer_idx.
  - Reading the status byte clears ovf and busy_err, except that an error event in the same cycle wins and stays set.
  - Reads at other addresses return 0 and have no side effects.
- Simultaneous write and read: both are serviced.
- Reset mid-run: the FSM returns to LOAD in one cycle, layer_start goes low, and all loads are lost.
- mem_offset = 0 whenever mem_we = 0.

Test Plan:
- Params 4/2/2/2/2. Write 4,2,2,2,2 bytes to regions 0-4 -> mem_offset 0..3 on region 0; layer_start=0001 one cycle after the last write; status reads 0x03.
- Return layer_done 0001, 0010, 0100, 1000, each 5 cycles after its start -> each next start follows 1 cycle after done; after the last done, irq=1 and status=0x65 (layer_idx=3, result_valid, all_loaded).
- In WAIT on layer 1, pulse layer_done=0100 -> no effect, state stays WAIT; a region-2 write -> mem_we=0, status bit4=1; a second status read -> bit4=0.
- Write a 5th byte to region 0 during LOAD -> dropped, ovf=1. Then control write 0x01 in FINISHED, plus 4 input bytes -> rerun starts without reloading weights.
- Assert reset while in WAIT on layer 2 -> next cycle status=0x00, layer_start=0, and region writes restart at offset 0.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// CNN accelerator load/run sequencer: region write strobes, layer start/done
// handshake and host status/control registers.
module cnn_layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int CNT_W      = 18,
    parameter int INPUT_SIZE = 10000,
    parameter int L1_SIZE    = 400,
    parameter int L2_SIZE    = 12800,
    parameter int L3_SIZE    = 230400,
    parameter int L4_SIZE    = 10600
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic                  read,
    input  logic [2:0]            address,
    input  logic [7:0]            writedata,
    output logic [4:0]            mem_we,
    output logic [CNT_W-1:0]      mem_offset,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [7:0]            readdata,
    output logic                  irq
);

    localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [CNT_W-1:0] SZ [5] = '{
        CNT_W'(INPUT_SIZE), CNT_W'(L1_SIZE), CNT_W'(L2_SIZE),
        CNT_W'(L3_SIZE), CNT_W'(L4_SIZE)
    };

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_FINISHED
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    logic [4:0]       loaded_q, loaded_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             rvalid_q, rvalid_d;
    logic             ovf_q, ovf_d;
    logic             berr_q, berr_d;
    logic [7:0]       rdata_q, rdata_d;

    logic wr, rd, idle, busy, err_ovf, err_busy, full_clr;
    logic [7:0] status;
    logic unused_wd;

    assign unused_wd = ^writedata[7:2];
    assign wr   = chipselect && write;
    assign rd   = chipselect && read;
    assign idle = (state_q == S_LOAD) || (state_q == S_FINISHED);
    assign busy = (state_q == S_RUN) || (state_q == S_WAIT);
    assign status = {3'(idx_q), berr_q, ovf_q, rvalid_q, busy, &loaded_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loaded_d   = loaded_q;
        idx_d      = idx_q;
        rvalid_d   = rvalid_q;
        ovf_d      = ovf_q;
        berr_d     = berr_q;
        rdata_d    = 8'h00;
        mem_we     = 5'b0;
        mem_offset = '0;
        err_ovf    = 1'b0;
        err_busy   = 1'b0;
        full_clr   = 1'b0;

        for (int r = 0; r < 5; r++) begin
            if (wr && address == 3'(r)) begin
                if (!idle) begin
                    err_busy = 1'b1;
                end else if (cnt_q[r] < SZ[r]) begin
                    mem_we[r]  = 1'b1;
                    mem_offset = cnt_q[r];
                    cnt_d[r]   = cnt_q[r] + CNT_W'(1);
                    if ((cnt_q[r] + CNT_W'(1)) == SZ[r])
                        loaded_d[r] = 1'b1;
                end else begin
                    err_ovf = 1'b1;
                end
            end
        end

        if (wr && address == 3'd6) begin
            if (!idle) begin
                err_busy = 1'b1;
            end else if (writedata[1]) begin
                full_clr = 1'b1;
                for (int r = 0; r < 5; r++)
                    cnt_d[r] = '0;
                loaded_d = 5'b0;
                rvalid_d = 1'b0;
                ovf_d    = 1'b0;
                berr_d   = 1'b0;
            end else if (writedata[0]) begin
                cnt_d[0]    = '0;
                loaded_d[0] = 1'b0;
                rvalid_d    = 1'b0;
            end
        end

        // Read-to-clear loses to an error raised in the same cycle
        if (rd && address == 3'd5) begin
            rdata_d = status;
            ovf_d   = 1'b0;
            berr_d  = 1'b0;
        end
        if (err_ovf)
            ovf_d = 1'b1;
        if (err_busy)
            berr_d = 1'b1;

        unique case (state_q)
            S_LOAD: begin
                if (&loaded_d) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                end
            end
            S_FINISHED: begin
                if (full_clr) begin
                    state_d = S_LOAD;
                end else if (loaded_d[0] && !loaded_q[0]) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (layer_done[idx_q]) begin
                    if (idx_q == IW'(NUM_LAYERS - 1)) begin
                        rvalid_d = 1'b1;
                        state_d  = S_FINISHED;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_LOAD;
            for (int r = 0; r < 5; r++)
                cnt_q[r] <= '0;
            loaded_q <= 5'b0;
            idx_q    <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            berr_q   <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
            idx_q    <= idx_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            berr_q   <= berr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign layer_start = (state_q == S_RUN) ?
                         (NUM_LAYERS'(1) << idx_q) : '0;
    assign readdata    = rdata_q;
    assign irq         = rvalid_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer with tiny region sizes (4/2/2/2/2).
module tb_cnn_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect, write, read;
    logic [2:0]  address;
    logic [7:0]  writedata;
    logic [4:0]  mem_we;
    logic [17:0] mem_offset;
    logic [3:0]  layer_start, layer_done;
    logic [7:0]  readdata;
    logic        irq;

    int n_vec = 0;
    int n_bad = 0;

    cnn_layer_sequencer #(
        .NUM_LAYERS(4), .CNT_W(18), .INPUT_SIZE(4),
        .L1_SIZE(2), .L2_SIZE(2), .L3_SIZE(2), .L4_SIZE(2)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect),
        .write(write), .read(read), .address(address),
        .writedata(writedata), .mem_we(mem_we),
        .mem_offset(mem_offset), .layer_start(layer_start),
        .layer_done(layer_done), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d,
                          input logic [4:0] exp_we,
                          input logic [17:0] exp_off);
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        #1;
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_offset", 32'(mem_offset), 32'(exp_off));
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic rd_status(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 3'd5;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        chk(tag, 32'(readdata), 32'(exp));
    endtask

    task automatic pulse_done(input logic [3:0] v);
        @(negedge clk);
        layer_done = v;
        @(posedge clk);
        #1;
        layer_done = 4'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1;
        chipselect = 1'b0;
        write = 1'b0;
        read = 1'b0;
        address = 3'd0;
        writedata = 8'h00;
        layer_done = 4'b0;
        gap(2);
        #1;
        chk("rst_readdata", 32'(readdata), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_start", 32'(layer_start), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rd_status("st_reset", 8'h00);

        for (int i = 0; i < 4; i++)
            bus_wr(3'd0, 8'hA0, 5'b00001, 18'(i));
        bus_wr(3'd0, 8'hA5, 5'b00000, 18'd0);
        rd_status("st_ovf", 8'h08);
        rd_status("st_ovf_clr", 8'h00);

        for (int r = 1; r < 5; r++) begin
            bus_wr(3'(r), 8'h11, 5'(1 << r), 18'd0);
            bus_wr(3'(r), 8'h22, 5'(1 << r), 18'd1);
        end
        chk("start0", 32'(layer_start), 32'b0001);
        gap(1);
        #1;
        chk("start0_one", 32'(layer_start), 32'b0000);
        rd_status("st_run0", 8'h03);

        gap(2);
        pulse_done(4'b0001);
        chk("start1", 32'(layer_start), 32'b0010);

        pulse_done(4'b0100);
        chk("wrong_done", 32'(layer_start), 32'b0000);
        rd_status("st_wait1", 8'h23);
        bus_wr(3'd2, 8'h33, 5'b00000, 18'd0);
        rd_status("st_berr", 8'h33);
        rd_status("st_berr_clr", 8'h23);

        gap(2);
        pulse_done(4'b0010);
        chk("start2", 32'(layer_start), 32'b0100);
        gap(4);
        pulse_done(4'b0100);
        chk("start3", 32'(layer_start), 32'b1000);
        chk("irq_busy", 32'(irq), 32'h0);
        gap(4);
        pulse_done(4'b1000);
        chk("start_none", 32'(layer_start), 32'b0000);
        chk("irq_done", 32'(irq), 32'h1);
        rd_status("st_final", 8'h65);

        bus_wr(3'd6, 8'h01, 5'b00000, 18'd0);
        chk("irq_newimg", 32'(irq), 32'h0);
        rd_status("st_newimg", 8'h60);
        for (int i = 0; i < 4; i++)
            bus_wr(3'd0, 8'hB0, 5'b00001, 18'(i));
        chk("rerun_start0", 32'(layer_start), 32'b0001);
        gap(2);
        pulse_done(4'b0001);
        chk("rerun_start1", 32'(layer_start), 32'b0010);
        gap(2);
        pulse_done(4'b0010);
        chk("rerun_start2", 32'(layer_start), 32'b0100);
        rd_status("st_wait2", 8'h43);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_start", 32'(layer_start), 32'b0000);
        @(negedge clk);
        reset = 1'b0;
        rd_status("st_after_rst", 8'h00);
        bus_wr(3'd1, 8'h44, 5'b00010, 18'd0);
        bus_wr(3'd0, 8'h55, 5'b00001, 18'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
